// File: rtl/svm_pkg.sv
// -----------------------------------------------------------------------------
// svm_pkg
// Shared definitions for the SVM kernel datapath: default widths, saturation
// limits for the 32-bit result and the accumulator controller state encoding.
// -----------------------------------------------------------------------------
package svm_pkg;

  localparam int PROD_WIDTH_D = 32;
  localparam int LEN_WIDTH_D  = 8;
  localparam int ACC_WIDTH_D  = PROD_WIDTH_D + LEN_WIDTH_D;
  localparam int OUT_WIDTH_D  = 32;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/svm_sat_trunc.sv
// -----------------------------------------------------------------------------
// svm_sat_trunc
// Combinational narrowing of a signed accumulator to a signed result with
// saturation toward the most positive / most negative representable value.
//
// Ports:
//   i_acc  in  ACC_WIDTH  signed (two's complement) accumulator value
//   o_res  out OUT_WIDTH  saturated / truncated result
//   o_ovf  out 1          high when the input did not fit and was clamped
// -----------------------------------------------------------------------------
module svm_sat_trunc
  import svm_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_D,
  parameter int OUT_WIDTH = OUT_WIDTH_D
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  output logic [OUT_WIDTH-1:0] o_res,
  output logic                 o_ovf
);

  localparam logic [OUT_WIDTH-1:0] W_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] W_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Returns {overflow, result}. The value fits exactly when every bit from the
  // result's sign bit upward is a copy of the same value.
  function automatic logic [OUT_WIDTH:0] sat_trunc(input logic [ACC_WIDTH-1:0] v);
    logic [ACC_WIDTH-OUT_WIDTH:0] hi;
    hi = v[ACC_WIDTH-1:OUT_WIDTH-1];
    if ((&hi) || (~|hi)) begin
      return {1'b0, v[OUT_WIDTH-1:0]};
    end else if (v[ACC_WIDTH-1]) begin
      return {1'b1, W_MIN};
    end else begin
      return {1'b1, W_MAX};
    end
  endfunction

  logic [OUT_WIDTH:0] w_sat;

  assign w_sat = sat_trunc(i_acc);
  assign o_ovf = w_sat[OUT_WIDTH];
  assign o_res = w_sat[OUT_WIDTH-1:0];

endmodule

// File: rtl/svm_dot_acc.sv
// -----------------------------------------------------------------------------
// svm_dot_acc
// Accumulates a vector of signed Q.16 products from the multiplier stage into
// one saturated dot-product value. A job starts on start (level, re-armed only
// after start drops), samples a product whenever start=1 and prod_busy=0,
// and finishes after vec_len samples with a one-cycle acc_done pulse.
//
// Ports:
//   clk        in   1           clock
//   rst_n      in   1           asynchronous active-low reset
//   start      in   1           level job enable (shared with multiplier start)
//   vec_len    in   LEN_WIDTH   number of products, latched at job start
//   prod_in    in   PROD_WIDTH  signed product from the multiplier
//   prod_busy  in   1           multiplier busy; product valid when low
//   acc_out    out  OUT_WIDTH   saturated result, held until next completion
//   acc_done   out  1           one-cycle pulse when acc_out updates
//   acc_busy   out  1           high while a job is collecting products
//   acc_ovf    out  1           saturation flag, valid with acc_done
// -----------------------------------------------------------------------------
module svm_dot_acc
  import svm_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_D,
  parameter int LEN_WIDTH  = LEN_WIDTH_D,
  parameter int ACC_WIDTH  = ACC_WIDTH_D,
  parameter int OUT_WIDTH  = OUT_WIDTH_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  vec_len,
  input  logic [PROD_WIDTH-1:0] prod_in,
  input  logic                  prod_busy,
  output logic [OUT_WIDTH-1:0]  acc_out,
  output logic                  acc_done,
  output logic                  acc_busy,
  output logic                  acc_ovf
);

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [LEN_WIDTH-1:0]         r_cnt;
  logic [LEN_WIDTH-1:0]         r_len;
  logic                         r_armed;
  logic [OUT_WIDTH-1:0]         r_acc_out;
  logic                         r_done;
  logic                         r_ovf;

  logic                         w_valid;
  logic                         w_last;
  logic                         w_job_start;
  logic                         w_take;
  logic                         w_abort;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic [OUT_WIDTH-1:0]         w_sat_res;
  logic                         w_sat_ovf;

  assign w_valid    = start & ~prod_busy;
  assign w_last     = (r_cnt == (r_len - LEN_WIDTH'(1)));
  assign w_prod_ext = ACC_WIDTH'($signed(prod_in));

  svm_sat_trunc #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat (
    .i_acc (r_acc),
    .o_res (w_sat_res),
    .o_ovf (w_sat_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // WAIT and ACC share the sampling rule; WAIT only marks "no sample yet".
  always_comb begin
    w_state_nxt = r_state;
    w_job_start = 1'b0;
    w_take      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && start) begin
          w_job_start = 1'b1;
          w_state_nxt = (vec_len == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT, ST_ACC: begin
        if (!start) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_valid) begin
          w_take      = 1'b1;
          w_state_nxt = w_last ? ST_DONE : ST_ACC;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_armed   <= 1'b1;
      r_acc_out <= '0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_job_start) begin
        r_len   <= vec_len;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
        r_armed <= 1'b0;
      end else if ((r_state == ST_IDLE) && !start) begin
        r_armed <= 1'b1;
      end

      if (w_abort) begin
        r_armed <= 1'b1;
      end

      if (w_take) begin
        r_acc <= r_acc + w_prod_ext;
        r_cnt <= r_cnt + LEN_WIDTH'(1);
      end

      // Result and flag are published together; armed stays low so a held
      // start cannot launch a second job.
      if (r_state == ST_DONE) begin
        r_acc_out <= w_sat_res;
        r_ovf     <= w_sat_ovf;
        r_done    <= 1'b1;
      end
    end
  end

  assign acc_out  = r_acc_out;
  assign acc_done = r_done;
  assign acc_ovf  = r_ovf;
  assign acc_busy = (r_state == ST_WAIT) || (r_state == ST_ACC);

endmodule

// File: tb/tb_svm_dot_acc.sv
// -----------------------------------------------------------------------------
// tb_svm_dot_acc
// Directed bench for svm_dot_acc. A transaction-level model tracks the job
// (collected samples as a running integer sum) and predicts outputs each cycle;
// directed scenarios additionally check hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_svm_dot_acc;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  vec_len;
  logic [31:0] prod_in;
  logic        prod_busy;
  logic [31:0] acc_out;
  logic        acc_done;
  logic        acc_busy;
  logic        acc_ovf;

  int tests;
  int fails;

  svm_dot_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec_len   (vec_len),
    .prod_in   (prod_in),
    .prod_busy (prod_busy),
    .acc_out   (acc_out),
    .acc_done  (acc_done),
    .acc_busy  (acc_busy),
    .acc_ovf   (acc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = no job, 1 = collecting samples, 2 = all samples in, publish next
  int          m_phase;
  bit          m_armed;
  int          m_len;
  int          m_cnt;
  longint      m_sum;
  logic [31:0] m_out;
  bit          m_done;
  bit          m_ovf;

  initial begin
    m_phase = 0; m_armed = 1; m_len = 0; m_cnt = 0; m_sum = 0;
    m_out = '0; m_done = 0; m_ovf = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_armed = 1; m_len = 0; m_cnt = 0; m_sum = 0;
      m_out = '0; m_done = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      case (m_phase)
        0: begin
          if (m_armed && start) begin
            m_len   = int'(vec_len);
            m_cnt   = 0;
            m_sum   = 0;
            m_ovf   = 0;
            m_armed = 0;
            m_phase = (m_len == 0) ? 2 : 1;
          end else if (!start) begin
            m_armed = 1;
          end
        end
        1: begin
          if (!start) begin
            m_phase = 0;
            m_armed = 1;
          end else if (!prod_busy) begin
            m_sum = m_sum + longint'($signed(prod_in));
            m_cnt++;
            if (m_cnt == m_len) m_phase = 2;
          end
        end
        default: begin
          if (m_sum > 64'sd2147483647) begin
            m_out = 32'h7FFF_FFFF; m_ovf = 1;
          end else if (m_sum < -64'sd2147483648) begin
            m_out = 32'h8000_0000; m_ovf = 1;
          end else begin
            m_out = m_sum[31:0]; m_ovf = 0;
          end
          m_done  = 1;
          m_phase = 0;
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("mdl_acc_out",  acc_out,  m_out);
        chk("mdl_acc_done", 32'(acc_done), 32'(m_done));
        chk("mdl_acc_busy", 32'(acc_busy), 32'(m_phase == 1));
        chk("mdl_acc_ovf",  32'(acc_ovf),  32'(m_ovf));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp_out, input logic exp_ovf);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (acc_done) seen = 1;
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_out"}, acc_out, exp_out);
    chk({name, "_ovf"}, 32'(acc_ovf), 32'(exp_ovf));
    step();
    chk({name, "_done_pulse1"}, 32'(acc_done), 32'd0);
  endtask

  task automatic feed(input logic [31:0] p);
    prod_in = p;
    step();
  endtask

  initial begin
    int ndone;
    tests = 0; fails = 0;
    rst_n = 0; start = 0; vec_len = '0; prod_in = '0; prod_busy = 0;
    step(); step();
    chk("rst_out",  acc_out, 32'd0);
    chk("rst_done", 32'(acc_done), 32'd0);
    chk("rst_busy", 32'(acc_busy), 32'd0);
    chk("rst_ovf",  32'(acc_ovf),  32'd0);
    rst_n = 1;
    step();

    // 1: 1.0 + 2.0 - 1.0 = 2.0 in Q.16
    start = 1; vec_len = 8'd3; prod_busy = 0; prod_in = 32'hDEAD_BEEF;
    step();
    chk("t1_busy", 32'(acc_busy), 32'd1);
    feed(32'h0001_0000); feed(32'h0002_0000); feed(32'hFFFF_0000);
    prod_in = 32'h1234_5678;
    wait_done("t1", 32'h0002_0000, 1'b0);

    // 2: positive then negative saturation
    start = 0; step();
    start = 1; vec_len = 8'd4; step();
    for (int i = 0; i < 4; i++) feed(32'h7FFF_FFFF);
    wait_done("t2pos", 32'h7FFF_FFFF, 1'b1);
    start = 0; step();
    start = 1; vec_len = 8'd2; step();
    feed(32'h8000_0000); feed(32'h8000_0000);
    wait_done("t2neg", 32'h8000_0000, 1'b1);

    // 3: multiplier busy stalls sampling
    start = 0; step();
    start = 1; vec_len = 8'd2; prod_busy = 1; step();
    for (int i = 0; i < 10; i++) feed(32'h0000_0100 + 32'(i));
    chk("t3_busy_hold", 32'(acc_busy), 32'd1);
    chk("t3_no_done", 32'(acc_done), 32'd0);
    prod_busy = 0;
    feed(32'd7); feed(32'd9);
    chk("t3_not_yet", 32'(acc_done), 32'd0);
    step();
    chk("t3_done_next", 32'(acc_done), 32'd1);
    chk("t3_out", acc_out, 32'd16);
    chk("t3_ovf", 32'(acc_ovf), 32'd0);

    // 4: abort after two samples, then a one-term job
    start = 0; step();
    start = 1; vec_len = 8'd5; step();
    feed(32'd1); feed(32'd2);
    start = 0; step();
    chk("t4_abort_busy", 32'(acc_busy), 32'd0);
    chk("t4_abort_out", acc_out, 32'd16);
    chk("t4_abort_done", 32'(acc_done), 32'd0);
    step(); step();
    start = 1; vec_len = 8'd1; step();
    feed(32'd5);
    wait_done("t4", 32'd5, 1'b0);

    // 5: zero-length job with start held high
    start = 0; step();
    start = 1; vec_len = 8'd0; prod_in = 32'h0F0F_0F0F; step();
    chk("t5_first", 32'(acc_done), 32'd0);
    step();
    chk("t5_done", 32'(acc_done), 32'd1);
    chk("t5_out", acc_out, 32'd0);
    ndone = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (acc_done) ndone++;
    end
    chk("t5_no_second", 32'(ndone), 32'd0);
    start = 0; step();
    start = 1; step(); step();
    chk("t5_rearm_done", 32'(acc_done), 32'd1);

    // 6: asynchronous reset mid-job
    start = 0; step();
    start = 1; vec_len = 8'd2; step();
    feed(32'h7FFF_FFFF); feed(32'h7FFF_FFFF);
    wait_done("t6pre", 32'h7FFF_FFFF, 1'b1);
    start = 0; step();
    start = 1; vec_len = 8'd4; step();
    feed(32'd1);
    chk("t6_in_acc", 32'(acc_busy), 32'd1);
    #3 rst_n = 0;
    #1;
    chk("t6_rst_out",  acc_out, 32'd0);
    chk("t6_rst_done", 32'(acc_done), 32'd0);
    chk("t6_rst_busy", 32'(acc_busy), 32'd0);
    chk("t6_rst_ovf",  32'(acc_ovf),  32'd0);
    start = 0;
    step(); step();
    rst_n = 1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (acc_done) ndone++;
    end
    chk("t6_no_done_after", 32'(ndone), 32'd0);
    chk("t6_out_after", acc_out, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/svm_dot_acc.md
Name: svm_dot_acc

Overview:
Downstream consumer of the 17-bit sign-magnitude multiplier stage. It accumulates a vector of signed 32-bit products (Q.16 scaled, two's complement) into one dot-product value for the SVM kernel evaluation. It gates sampling on the multiplier's start/busy handshake, counts products against a programmable vector length, and emits a saturated 32-bit result with a one-cycle done pulse.

Parameters:
PROD_WIDTH, 32, width of incoming product (two's complement)
LEN_WIDTH, 8, width of vector-length field (max 255 terms)
ACC_WIDTH, 40, internal accumulator width (PROD_WIDTH+LEN_WIDTH; no internal overflow possible)
OUT_WIDTH, 32, width of saturated result

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level job enable; same signal that drives the multiplier start
vec_len  in  LEN_WIDTH  number of products to accumulate; latched at job start
prod_in  in  PROD_WIDTH  product from multiplier (data_three)
prod_busy  in  1  multiplier busy (busy_three); product valid when start=1 and prod_busy=0
acc_out  out  OUT_WIDTH  saturated dot-product result; holds until next job completes
acc_done  out  1  one-cycle pulse when acc_out is updated
acc_busy  out  1  high while a job is in progress
acc_ovf  out  1  set with acc_done if saturation occurred; cleared at next job start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, cnt=0, len_reg=0, armed=1, acc_out=0, acc_done=0, acc_busy=0, acc_ovf=0. Reset mid-job aborts it immediately; no done is issued.
- States: IDLE, WAIT, ACC, DONE.
- IDLE: when armed=1 and start=1: latch len_reg<=vec_len, acc<=0, cnt<=0, acc_ovf<=0, armed<=0. If vec_len=0, go to DONE; otherwise go to WAIT. When start=0, armed<=1. Jobs are started by level with rearm: start must drop before a new job is accepted.
- WAIT: acc_busy=1. valid = start & ~prod_busy. On valid, go to ACC and accumulate in that same cycle, exactly as in the ACC rule below.
- ACC: acc_busy=1. On each valid cycle: acc <= acc + sign-extend(prod_in) and cnt <= cnt+1. When a sample is taken with cnt = len_reg-1 (the last term), go to DONE. A valid=0 cycle with start=1 (prod_busy high) is a stall: hold acc and cnt.
- Abort: start=0 in WAIT or ACC returns to IDLE with acc_busy=0 next cycle. acc_out, acc_done and acc_ovf are unchanged; armed<=1.
- DONE (one cycle): acc_out <= sat(acc); acc_done <= 1; acc_ovf <= saturated; acc_busy=0; go to IDLE. armed stays 0 until start is seen low.
- Latency: the edge that samples the last product is followed by the next edge, which registers acc_out and acc_done=1. acc_done falls one cycle later.
- Saturation: if acc > 2^31-1, output 0x7FFFFFFF; if acc < -2^31, output 0x80000000; otherwise acc[31:0].
- Inputs are consumed only while acc_busy=1; prod_in is ignored in IDLE and DONE.

Decomposition:
- Shared package svm_pkg: state encoding constants (IDLE/WAIT/ACC/DONE), SAT_MAX = 32'h7FFFFFFF, SAT_MIN = 32'h80000000, default widths.
- One combinational sub-module, svm_sat_trunc (ACC_WIDTH -> OUT_WIDTH, with overflow flag), reusable by later kernel stages.

Test Plan:
- vec_len=3, prod_busy low, prods 0x00010000, 0x00020000, 0xFFFF0000 -> acc_out=0x00020000, single acc_done pulse, acc_ovf=0.
- vec_len=4, four prods of 0x7FFFFFFF -> acc_out=0x7FFFFFFF, acc_ovf=1; then vec_len=2 with prods 0x80000000 ×2 -> acc_out=0x80000000, acc_ovf=1.
- start=1 with prod_busy high for 10 cycles, then low; vec_len=2, prods 7, 9 -> no accumulation during busy; acc_out=16, acc_done 1 cycle after the 2nd sample.
- Previous acc_out=16; vec_len=5, start dropped after 2 samples -> no acc_done, acc_busy=0 next cycle, acc_out stays 16. Restart with vec_len=1, prod 5 -> acc_out=5.
- vec_len=0 with start held high for 20 cycles -> exactly one acc_done (1 cycle after start), acc_out=0, no second job until start toggles low.
- rst_n pulsed low mid-ACC -> acc_out, acc_done, acc_busy and acc_ovf read 0 immediately (asynchronously); no done afterwards.
